// File: rtl/sddac_ctrl.sv
// sddac_ctrl: 2nd-order sigma-delta DAC that drives an external registered 48-bit adder.
// Define SDDAC_CTRL_CLAMP_EN to saturate both integrators to +/-ACC_LIMIT.
module sddac_ctrl #(
    parameter int FS        = 32768,
    parameter int ACC_LIMIT = 1048576
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic [8:0]         opmode,
    output logic signed [47:0] dabin,
    output logic signed [47:0] cin,
    input  logic signed [47:0] pout,
    output logic               dac_out,
    output logic               step_done
);
    localparam logic [2:0] IDLE = 3'd0, OP1 = 3'd1, OP2 = 3'd2, OP3 = 3'd3, OP4 = 3'd4, CAP = 3'd5;
    localparam logic [8:0] OP_ADD = 9'h00F, OP_SUB = 9'h08F, OP_NOP = 9'h000;
    localparam logic signed [47:0] FB_POS = 48'(FS);
    localparam logic signed [47:0] FB_NEG = -FB_POS;
    logic [2:0]         state;
    logic signed [15:0] x_reg;
    logic signed [47:0] acc1, acc2, fbv, acc_wr;
    logic               is_sub;
`ifdef SDDAC_CTRL_CLAMP_EN
    localparam logic signed [47:0] LIM_POS = 48'(ACC_LIMIT);
    localparam logic signed [47:0] LIM_NEG = -LIM_POS;
    assign acc_wr = pout > LIM_POS ? LIM_POS : pout < LIM_NEG ? LIM_NEG : pout;
`else
    assign acc_wr = pout;
`endif
    // Feedback follows the previous step's bit; dac_out only moves at the end of CAP.
    assign fbv          = dac_out ? FB_POS : FB_NEG;
    assign is_sub       = state == OP2 || state == OP4;
    assign sample_ready = state == IDLE;
    assign step_done    = state == CAP;
    assign opmode       = (state == OP1 || state == OP3) ? OP_ADD : is_sub ? OP_SUB : OP_NOP;
    assign cin          = state == OP1 ? acc1 : (is_sub || state == OP3) ? pout : '0;
    assign dabin        = state == OP1 ? 48'(x_reg) : state == OP3 ? acc2 : is_sub ? fbv : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            x_reg   <= '0;
            acc1    <= '0;
            acc2    <= '0;
            dac_out <= 1'b0;
        end else begin
            state <= state == IDLE ? (sample_valid ? OP1 : IDLE) : state == CAP ? IDLE : state + 3'd1;
            if (state == IDLE && sample_valid) x_reg <= sample_in;
            if (state == OP3) acc1 <= acc_wr;
            if (state == CAP) begin
                acc2    <= acc_wr;
                dac_out <= ~pout[47];
            end
        end
    end
endmodule

// File: tb/tb_sddac_ctrl.sv
// tb_sddac_ctrl: random and directed steps against a per-sample sigma-delta reference model,
// with a behavioural registered adder standing in for the external 48-bit adder.
module tb_sddac_ctrl;
    localparam longint LIM = 1048576;
    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               sample_ready, dac_out, step_done;
    logic [8:0]         opmode;
    logic signed [47:0] dabin, cin;
    logic signed [47:0] pout = '0;
    int                 n_chk = 0, n_fail = 0;
    longint             m_acc1 = 0, m_acc2 = 0;
    logic               m_y = 1'b0;
    longint             obs_cin, obs_dab;
    logic [8:0]         ops [5] = '{9'h00F, 9'h08F, 9'h00F, 9'h08F, 9'h000};

    sddac_ctrl dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .opmode(opmode), .dabin(dabin), .cin(cin),
        .pout(pout), .dac_out(dac_out), .step_done(step_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        pout <= opmode == 9'h00F ? cin + dabin : opmode == 9'h08F ? cin - dabin : 48'sd0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v);
`ifdef SDDAC_CTRL_CLAMP_EN
        return v > LIM ? LIM : v < -LIM ? -LIM : v;
`else
        return v;
`endif
    endfunction

    // One modulator sample: two integrators with +/-FS feedback from the previous output bit.
    task automatic model_step(input longint x);
        longint fb, u1, s;
        fb = m_y ? 32768 : -32768;
        u1 = m_acc1 + x - fb;
        s = u1 + m_acc2 - fb;
        m_acc1 = sat(u1);
        m_acc2 = sat(s);
        m_y = s >= 0;
    endtask

    task automatic model_reset();
        m_acc1 = 0;
        m_acc2 = 0;
        m_y = 1'b0;
    endtask

    task automatic apply_reset();
        sample_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic do_step(input logic signed [15:0] x);
        int n = 0;
        @(negedge clk);
        while (!sample_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", n < 20, 1);
        sample_in = x;
        sample_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            sample_in = 16'($urandom);
            check("opmode", opmode, ops[i-1]);
            check("ready_busy", sample_ready, 0);
            check("step_done", step_done, i == 5);
            if (i == 1) begin
                obs_cin = cin;
                check("op1_cin_acc1", cin, m_acc1);
                check("op1_dabin_x", dabin, longint'(x));
            end
            if (i == 3) begin
                obs_dab = dabin;
                check("op3_dabin_acc2", dabin, m_acc2);
`ifdef SDDAC_CTRL_CLAMP_EN
                check("acc_in_range", obs_cin <= LIM && obs_cin >= -LIM && obs_dab <= LIM && obs_dab >= -LIM, 1);
`endif
            end
        end
        model_step(longint'(x));
        @(posedge clk);
        #1;
        check("dac_out", dac_out, m_y);
        check("done_low", step_done, 0);
        check("ready_idle", sample_ready, 1);
    endtask

    initial begin
        int ones;
        #23;
        check("rst_opmode", opmode, 0);
        check("rst_dabin", dabin, 0);
        check("rst_cin", cin, 0);
        check("rst_dac", dac_out, 0);
        check("rst_done", step_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_ready", sample_ready, 1);
        // zero input from reset: known bit and integrator sequence
        do_step(16'sd0);
        check("zero1_dac", dac_out, 1);
        do_step(16'sd0);
        check("zero2_dac", dac_out, 1);
        check("zero1_acc1", obs_cin, 32768);
        check("zero1_acc2", obs_dab, 65536);
        do_step(16'sd0);
        check("zero3_dac", dac_out, 0);
        check("zero2_acc1", obs_cin, 0);
        check("zero2_acc2", obs_dab, 32768);
        do_step(16'sd0);
        check("zero3_acc1", obs_cin, -32768);
        check("zero3_acc2", obs_dab, -32768);
        for (int k = 0; k < 300; k++) do_step(16'($urandom));
        // reset in the middle of OP3 abandons the step
        @(negedge clk);
        while (!sample_ready) @(negedge clk);
        sample_in = 16'sd1234;
        sample_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_op3", opmode, 9'h00F);
        sample_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_opmode", opmode, 0);
        check("mid_rst_dabin", dabin, 0);
        check("mid_rst_cin", cin, 0);
        check("mid_rst_dac", dac_out, 0);
        check("mid_rst_done", step_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        do_step(16'sd0);
        check("post_rst_dac", dac_out, 1);
        do_step(16'sd0);
        check("post_rst_acc2", obs_dab, 65536);
        apply_reset();
        ones = 0;
        for (int k = 0; k < 1024; k++) begin
            do_step(16'sd16384);
            ones += int'(dac_out);
        end
        check("density_768", ones >= 764 && ones <= 772, 1);
        apply_reset();
        for (int k = 0; k < 200; k++) do_step(16'sd32767);
        for (int k = 0; k < 100; k++) do_step(16'($urandom_range(0, 1) ? 16'sd32767 : -16'sd32768));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
